// File: rtl/keypad_entry_ctrl.sv
// 4x4 active-low keypad scanner with debounce, one event per press and a BCD entry buffer.
// Optional build macro KEY_AUTOREPEAT_EN enables auto-repeat of held digit/BACKSPACE keys.
module keypad_entry_ctrl #(
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned DEBOUNCE   = 4,
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned REPEAT_DLY = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          col_in,
  output logic [3:0]          row_out,
  output logic [15:0]         onehot,
  output logic                key_valid,
  output logic [4*DIGITS-1:0] digit_buf,
  output logic [3:0]          count,
  output logic                overflow
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BufW = 4 * DIGITS;

  if (DIGITS < 1 || DIGITS > 7 || SCAN_DIV < 1 || DEBOUNCE < 1 || REPEAT_DLY < 1)
  begin : g_param_check
    $error("keypad_entry_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {StScan, StDebounce, StPressed, StRelease} state_e;

  state_e            state_q, state_d;
  logic [3:0]        col_s1_q, col_s2_q;
  logic [DivW-1:0]   div_q;
  logic [1:0]        row_q, row_d, col_q, col_d;
  logic [3:0]        pat_q, pat_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       onehot_q, onehot_d;
  logic              key_valid_q, key_valid_d, overflow_q, overflow_d;
  logic [BufW-1:0]   buf_q, buf_d;
  logic [3:0]        count_q, count_d;
`ifdef KEY_AUTOREPEAT_EN
  logic [15:0]       hold_q, hold_d;
`endif

  logic       tick;
  logic [3:0] key_idx;
  logic [2:0] low_col;
  logic [4:0] dig;

  // Returns {valid, column} when exactly one column is pulled low.
  function automatic logic [2:0] find_col(input logic [3:0] s);
    case (s)
      4'b1110: find_col = 3'b100;
      4'b1101: find_col = 3'b101;
      4'b1011: find_col = 3'b110;
      4'b0111: find_col = 3'b111;
      default: find_col = 3'b000;
    endcase
  endfunction

  // Returns {is_digit, bcd} for a key index.
  function automatic logic [4:0] digit_of(input logic [3:0] k);
    case (k)
      4'd3:    digit_of = 5'h10;
      4'd7:    digit_of = 5'h11;
      4'd6:    digit_of = 5'h12;
      4'd5:    digit_of = 5'h13;
      4'd11:   digit_of = 5'h14;
      4'd10:   digit_of = 5'h15;
      4'd9:    digit_of = 5'h16;
      4'd15:   digit_of = 5'h17;
      4'd14:   digit_of = 5'h18;
      4'd13:   digit_of = 5'h19;
      default: digit_of = 5'h00;
    endcase
  endfunction

  assign tick    = (div_q == DivW'(SCAN_DIV - 1));
  assign key_idx = {row_q, col_q};
  assign low_col = find_col(col_s2_q);
  assign dig     = digit_of(key_idx);

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    pat_d       = pat_q;
    cnt_d       = cnt_q;
    onehot_d    = onehot_q;
    key_valid_d = 1'b0;
    overflow_d  = 1'b0;
    buf_d       = buf_q;
    count_d     = count_q;
`ifdef KEY_AUTOREPEAT_EN
    hold_d      = hold_q;
`endif
    case (state_q)
      StScan: begin
        if (tick) begin
          if (low_col[2]) begin
            col_d   = low_col[1:0];
            pat_d   = col_s2_q;
            cnt_d   = 16'd1;
            state_d = (DEBOUNCE <= 1) ? StPressed : StDebounce;
          end else begin
            row_d = row_q + 2'd1;
          end
        end
      end
      StDebounce: begin
        if (tick) begin
          if (col_s2_q == pat_q) begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q + 16'd1 >= 16'(DEBOUNCE)) state_d = StPressed;
          end else begin
            state_d = StScan;
          end
        end
      end
      StPressed: begin
        onehot_d    = 16'd1 << key_idx;
        key_valid_d = 1'b1;
        if (dig[4]) begin
          if (count_q < 4'(DIGITS)) begin
            buf_d   = (buf_q << 4) | BufW'(dig[3:0]);
            count_d = count_q + 4'd1;
          end else begin
            overflow_d = 1'b1;
          end
        end else if (key_idx == 4'd0) begin
          buf_d   = '0;
          count_d = 4'd0;
        end else if (key_idx == 4'd4 && count_q != 4'd0) begin
          buf_d   = buf_q >> 4;
          count_d = count_q - 4'd1;
        end
        cnt_d   = 16'd0;
`ifdef KEY_AUTOREPEAT_EN
        hold_d  = 16'd0;
`endif
        state_d = StRelease;
      end
      StRelease: begin
        if (tick) begin
          if (col_s2_q == 4'hF) begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q + 16'd1 >= 16'(DEBOUNCE)) begin
              state_d = StScan;
              row_d   = 2'd0;
            end
          end else begin
            cnt_d = 16'd0;
          end
`ifdef KEY_AUTOREPEAT_EN
          if (col_s2_q == pat_q) begin
            hold_d = hold_q + 16'd1;
            if (hold_q + 16'd1 >= 16'(REPEAT_DLY) && (dig[4] || key_idx == 4'd4))
              state_d = StPressed;
          end else begin
            hold_d = 16'd0;
          end
`endif
        end
      end
      default: state_d = StScan;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StScan;
      col_s1_q    <= 4'hF;
      col_s2_q    <= 4'hF;
      div_q       <= '0;
      row_q       <= 2'd0;
      col_q       <= 2'd0;
      pat_q       <= 4'hF;
      cnt_q       <= 16'd0;
      onehot_q    <= 16'd0;
      key_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      buf_q       <= '0;
      count_q     <= 4'd0;
`ifdef KEY_AUTOREPEAT_EN
      hold_q      <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      col_s1_q    <= col_in;
      col_s2_q    <= col_s1_q;
      div_q       <= tick ? '0 : div_q + DivW'(1);
      row_q       <= row_d;
      col_q       <= col_d;
      pat_q       <= pat_d;
      cnt_q       <= cnt_d;
      onehot_q    <= onehot_d;
      key_valid_q <= key_valid_d;
      overflow_q  <= overflow_d;
      buf_q       <= buf_d;
      count_q     <= count_d;
`ifdef KEY_AUTOREPEAT_EN
      hold_q      <= hold_d;
`endif
    end
  end

  assign row_out   = ~(4'b0001 << row_q);
  assign onehot    = onehot_q;
  assign key_valid = key_valid_q;
  assign overflow  = overflow_q;
  assign digit_buf = buf_q;
  assign count     = count_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl: a virtual key matrix driven from row_out.
module tb_keypad_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [15:0] onehot;
  logic        key_valid;
  logic [15:0] digit_buf;
  logic [3:0]  count;
  logic        overflow;

  logic       key_en;
  logic [1:0] key_row;
  logic [3:0] key_cols;

  int n_cmp = 0;
  int n_err = 0;
  int kv_cnt = 0, ov_cnt = 0, dbl_cnt = 0;
  logic kv_prev = 1'b0, ov_prev = 1'b0;
  int cyc;

  keypad_entry_ctrl #(
    .SCAN_DIV(4), .DEBOUNCE(2), .DIGITS(4), .REPEAT_DLY(64)
  ) dut (
    .clk(clk), .rst(rst), .col_in(col_in), .row_out(row_out), .onehot(onehot),
    .key_valid(key_valid), .digit_buf(digit_buf), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Pressed columns read low only while their row is driven low.
  always_comb col_in = (key_en && row_out[key_row] == 1'b0) ? ~key_cols : 4'hF;

  // Clocks since reset; multiples of 4 are the DUT's column sample edges.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (key_valid) kv_cnt <= kv_cnt + 1;
    if (overflow) ov_cnt <= ov_cnt + 1;
    if ((key_valid && kv_prev) || (overflow && ov_prev)) dbl_cnt <= dbl_cnt + 1;
    kv_prev <= key_valid;
    ov_prev <= overflow;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, required finish before timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to #1 after the next column sample edge.
  task automatic samp();
    do begin
      @(posedge clk);
      #1;
    end while (cyc % 4 != 0);
  endtask

  task automatic press(input logic [1:0] r, input logic [3:0] c, input int hold);
    key_row  = r;
    key_cols = c;
    key_en   = 1'b1;
    repeat (hold) samp();
    key_en = 1'b0;
    repeat (4) samp();
  endtask

  int kv0, ov0, n;
  logic [3:0] seen;

  initial begin
    rst = 1'b1; key_en = 1'b0; key_row = 2'd0; key_cols = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("rst_row_out", 16'(row_out), 16'h000E);
    chk("rst_onehot", onehot, 16'h0000);
    chk("rst_digit_buf", digit_buf, 16'h0000);
    chk("rst_count", 16'(count), 16'h0000);
    chk("rst_key_valid", 16'(key_valid), 16'h0000);
    chk("rst_overflow", 16'(overflow), 16'h0000);

    // Reset while debouncing key 0 (row 0, col 3).
    kv0 = kv_cnt;
    key_row = 2'd0; key_cols = 4'b1000; key_en = 1'b1;
    samp();
    rst = 1'b1;
    key_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_row_out", 16'(row_out), 16'h000E);
    chk("midrst_onehot", onehot, 16'h0000);
    chk("midrst_count", 16'(count), 16'h0000);
    chk("midrst_no_event", 16'(kv_cnt - kv0), 16'd0);
    @(negedge clk) rst = 1'b0;

    // Single press of digit 1 held for 20 slots.
    kv0 = kv_cnt;
    press(2'd1, 4'b1000, 20);
    chk("single_events", 16'(kv_cnt - kv0), 16'd1);
    chk("single_onehot", onehot, 16'h0080);
    chk("single_buf", digit_buf, 16'h0001);
    chk("single_count", 16'(count), 16'd1);

    // Bounce on digit 0: low, high, then a stable low pair.
    n = 0;
    while (row_out !== 4'b1110 && n < 8) begin
      samp();
      n++;
    end
    chk("bounce_row0_sync", 16'(row_out), 16'h000E);
    kv0 = kv_cnt;
    key_row = 2'd0; key_cols = 4'b1000; key_en = 1'b1;
    samp();
    key_en = 1'b0;
    samp();
    key_en = 1'b1;
    samp();
    chk("bounce_no_early", 16'(kv_cnt - kv0), 16'd0);
    samp();
    repeat (3) @(posedge clk);
    #1;
    chk("bounce_one_event", 16'(kv_cnt - kv0), 16'd1);
    key_en = 1'b0;
    repeat (4) samp();
    chk("bounce_onehot", onehot, 16'h0008);
    chk("bounce_buf", digit_buf, 16'h0010);
    chk("bounce_count", 16'(count), 16'd2);

    press(2'd0, 4'b0001, 8);  // CLEAR
    chk("clear1_onehot", onehot, 16'h0001);
    chk("clear1_buf", digit_buf, 16'h0000);
    chk("clear1_count", 16'(count), 16'd0);

    press(2'd1, 4'b1000, 8);  // 1
    press(2'd1, 4'b0100, 8);  // 2
    press(2'd1, 4'b0010, 8);  // 3
    press(2'd2, 4'b1000, 8);  // 4
    chk("entry_buf", digit_buf, 16'h1234);
    chk("entry_count", 16'(count), 16'd4);

    kv0 = kv_cnt; ov0 = ov_cnt;
    press(2'd2, 4'b0100, 8);  // 5 into a full buffer
    chk("ovf_event", 16'(kv_cnt - kv0), 16'd1);
    chk("ovf_pulse", 16'(ov_cnt - ov0), 16'd1);
    chk("ovf_onehot", onehot, 16'h0400);
    chk("ovf_buf", digit_buf, 16'h1234);
    chk("ovf_count", 16'(count), 16'd4);

    press(2'd1, 4'b0001, 8);  // BACKSPACE
    chk("bksp_buf", digit_buf, 16'h0123);
    chk("bksp_count", 16'(count), 16'd3);

    press(2'd0, 4'b0001, 8);  // CLEAR
    chk("clear2_buf", digit_buf, 16'h0000);
    chk("clear2_count", 16'(count), 16'd0);

    kv0 = kv_cnt; ov0 = ov_cnt;
    press(2'd1, 4'b0001, 8);  // BACKSPACE on empty buffer
    chk("bksp0_event", 16'(kv_cnt - kv0), 16'd1);
    chk("bksp0_no_ovf", 16'(ov_cnt - ov0), 16'd0);
    chk("bksp0_onehot", onehot, 16'h0010);
    chk("bksp0_buf", digit_buf, 16'h0000);
    chk("bksp0_count", 16'(count), 16'd0);

    press(2'd3, 4'b0010, 8);  // 9
    press(2'd0, 4'b0100, 8);  // function key, bit 2
    chk("func_onehot", onehot, 16'h0004);
    chk("func_buf", digit_buf, 16'h0009);
    chk("func_count", 16'(count), 16'd1);

    // Ghosting: two columns low in row 2.
    kv0 = kv_cnt;
    seen = 4'h0;
    key_row = 2'd2; key_cols = 4'b0011; key_en = 1'b1;
    repeat (12) begin
      samp();
      seen |= ~row_out;
    end
    key_en = 1'b0;
    chk("ghost_no_event", 16'(kv_cnt - kv0), 16'd0);
    chk("ghost_rows_rotate", 16'(seen), 16'h000F);
    chk("ghost_onehot", onehot, 16'h0004);

    chk("pulse_width", 16'(dbl_cnt), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
